fir_lut_loader: RTL and testbench

Runtime loader for the distributed-arithmetic FIR coefficient LUTs. It accepts one coefficient per tap over a valid/ready handshake and generates the 16-entry product table `coef*j` for each tap by repeated addition, with no multiplier. It drives a write port into the per-tap LUT memories, so coefficients can change without re-elaboration. It sits between the control/host interface and the FIR tap LUT bank.

---
 rtl/fir_lut_pkg.sv | 9 +
 rtl/fir_lut_loader_if.sv | 19 +
 rtl/fir_lut_loader_mult_gen.sv | 38 +++
 rtl/fir_lut_loader.sv | 76 +++++++
 tb/tb_fir_lut_loader.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fir_lut_pkg.sv
// fir_lut_pkg: shared widths and loader state encoding for the FIR LUT loader
package fir_lut_pkg;
  localparam int NTAPS = 10;
  localparam int IN_W = 4;
  localparam int COEF_W = 4;
  localparam int OUT_W = 8;
  localparam int TAP_W = $clog2(NTAPS);
  typedef enum logic [1:0] {IDLE, WAIT_COEF, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/fir_lut_loader_if.sv
// fir_lut_loader_if: host coefficient handshake plus LUT-bank write port
interface fir_lut_loader_if;
  import fir_lut_pkg::*;
  logic start;
  logic [COEF_W-1:0] coef;
  logic coef_valid;
  logic coef_ready;
  logic wr_en;
  logic [TAP_W-1:0] wr_tap;
  logic [IN_W-1:0] wr_addr;
  logic [OUT_W-1:0] wr_data;
  logic busy;
  logic done;
  logic [15:0] checksum;
  modport master(output start, coef, coef_valid,
                 input coef_ready, wr_en, wr_tap, wr_addr, wr_data, busy, done, checksum);
  modport slave(input start, coef, coef_valid,
                output coef_ready, wr_en, wr_tap, wr_addr, wr_data, busy, done, checksum);
endinterface

// File: rtl/fir_lut_loader_mult_gen.sv
// lut_mult_gen: builds coef*j for j = 0..2**IN_W-1 by repeated addition
module lut_mult_gen
  import fir_lut_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [COEF_W-1:0] coef,
  output logic [OUT_W-1:0]  acc,
  output logic [IN_W-1:0]   addr,
  output logic              last
);
  logic [COEF_W-1:0] coef_q, coef_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [IN_W-1:0] addr_q, addr_d;
  // clear latches a new coefficient and restarts the table; step advances one entry
  always_comb begin
    coef_d = clear ? coef : coef_q;
    acc_d = clear ? '0 : step ? acc_q + OUT_W'(coef_q) : acc_q;
    addr_d = clear ? '0 : step ? addr_q + 1'b1 : addr_q;
  end
  // generator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q <= '0;
      acc_q <= '0;
      addr_q <= '0;
    end else begin
      coef_q <= coef_d;
      acc_q <= acc_d;
      addr_q <= addr_d;
    end
  end
  assign acc = acc_q;
  assign addr = addr_q;
  assign last = &addr_q;
endmodule

// File: rtl/fir_lut_loader.sv
// fir_lut_loader: loads per-tap coef*j product LUTs; FIR_LUT_LOADER_CHECKSUM_EN adds a write checksum
module fir_lut_loader
  import fir_lut_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fir_lut_loader_if.slave bus
);
  loader_state_t state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic clear, step, last, last_tap;
  logic [OUT_W-1:0] acc;
  logic [IN_W-1:0] addr;
  assign last_tap = tap_q == TAP_W'(NTAPS - 1);
  lut_mult_gen u_gen (
    .clk(clk), .rst(rst), .clear(clear), .step(step),
    .coef(bus.coef), .acc(acc), .addr(addr), .last(last)
  );
  // next state, tap advance and generator control
  always_comb begin
    state_d = state_q;
    tap_d = tap_q;
    clear = 1'b0;
    step = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = WAIT_COEF;
        tap_d = '0;
        clear = 1'b1;
      end
      WAIT_COEF: if (bus.coef_valid) begin
        state_d = WRITE;
        clear = 1'b1;
      end
      WRITE: begin
        step = 1'b1;
        if (last) begin
          state_d = last_tap ? DONE : WAIT_COEF;
          tap_d = last_tap ? tap_q : tap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and tap registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q <= tap_d;
    end
  end
  assign bus.coef_ready = state_q == WAIT_COEF;
  assign bus.wr_en = state_q == WRITE;
  assign bus.wr_tap = tap_q;
  assign bus.wr_addr = addr;
  assign bus.wr_data = acc;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
`ifdef FIR_LUT_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  // running sum of written entries, restarted by a new load
  always_comb sum_d = (state_q == IDLE && bus.start) ? '0 :
                      (state_q == WRITE) ? sum_q + 16'(acc) : sum_q;
  // checksum register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign bus.checksum = sum_q;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_fir_lut_loader.sv
// tb_fir_lut_loader: directed scenarios against a queue model of expected LUT writes
module tb_fir_lut_loader;
  import fir_lut_pkg::*;
  typedef struct {int tap; int addr; int data;} wr_t;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int exp_sum = 0;
  wr_t q[$];
  logic [3:0] cs[10];
  fir_lut_loader_if bus();
  fir_lut_loader dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask
  // expected write stream: every tap t writes cs[t]*j for j = 0..15 in order
  function automatic void build();
    int d;
    q.delete();
    exp_sum = 0;
    for (int t = 0; t < 10; t++)
      for (int j = 0; j < 16; j++) begin
        d = (int'(cs[t]) * j) % 256;
        q.push_back('{t, j, d});
        exp_sum = (exp_sum + d) % 65536;
      end
  endfunction
  always @(negedge clk) begin : cmp
    wr_t e;
    if (!rst && bus.wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_write: got write tap %0d addr %0d, expected none", bus.wr_tap, bus.wr_addr);
      end else begin
        e = q.pop_front();
        chk("wr_tap", int'(bus.wr_tap), e.tap);
        chk("wr_addr", int'(bus.wr_addr), e.addr);
        chk("wr_data", int'(bus.wr_data), e.data);
      end
    end
  end
  task automatic do_start();
    @(posedge clk);
    #1 bus.start = 1;
    @(posedge clk);
    #1 c0 = cyc;
    bus.start = 0;
  endtask
  task automatic feed(input int t, input int stall);
    int k;
    bus.coef = cs[t];
    bus.coef_valid = (stall == 0);
    k = 0;
    while (!bus.coef_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("coef_ready_wait", int'(bus.coef_ready), 1);
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_ready", int'(bus.coef_ready), 1);
      chk("stall_wr_en", int'(bus.wr_en), 0);
    end
    bus.coef_valid = 1;
    @(posedge clk);
    #1 bus.coef_valid = 0;
  endtask
  task automatic run(input int stall_tap, input int stall_len, input bit disturb);
    int k;
    do_start();
    for (int t = 0; t < 10; t++) begin
      feed(t, t == stall_tap ? stall_len : 0);
      if (disturb && t == 2) begin
        bus.start = 1;
        bus.coef_valid = 1;
        bus.coef = 4'hF;
        repeat (3) @(posedge clk);
        #1 bus.start = 0;
        bus.coef_valid = 0;
      end
    end
    k = 0;
    while (!bus.done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", int'(bus.done), 1);
    chk("done_latency", cyc - c0, 170 + stall_len);
`ifdef FIR_LUT_LOADER_CHECKSUM_EN
    chk("checksum", int'(bus.checksum), exp_sum);
`else
    chk("checksum", int'(bus.checksum), 0);
`endif
    chk("writes_left", q.size(), 0);
    @(negedge clk);
    chk("done_pulse", int'(bus.done), 0);
    chk("busy_after", int'(bus.busy), 0);
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_ready"}, int'(bus.coef_ready), 0);
    chk({n, "_wr_en"}, int'(bus.wr_en), 0);
    chk({n, "_wr_tap"}, int'(bus.wr_tap), 0);
    chk({n, "_wr_addr"}, int'(bus.wr_addr), 0);
    chk({n, "_wr_data"}, int'(bus.wr_data), 0);
    chk({n, "_busy"}, int'(bus.busy), 0);
    chk({n, "_done"}, int'(bus.done), 0);
    chk({n, "_checksum"}, int'(bus.checksum), 0);
  endtask
  initial begin
    int k;
    bus.start = 0;
    bus.coef = 0;
    bus.coef_valid = 0;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 0;
    bus.coef_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ignores_valid_busy", int'(bus.busy), 0);
      chk("idle_ignores_valid_ready", int'(bus.coef_ready), 0);
    end
    bus.coef_valid = 0;
    for (int t = 0; t < 10; t++) cs[t] = 4'(t + 1);
    build();
    chk("model_t2_a5", q[37].data, 15);
    chk("model_t9_a15", q[159].data, 150);
    chk("model_sum", exp_sum, 6600);
    run(-1, 0, 0);
    for (int t = 0; t < 10; t++) cs[t] = 4'hF;
    build();
    chk("model_max_t0", q[15].data, 225);
    chk("model_max_t9", q[159].data, 225);
    run(-1, 0, 0);
    for (int t = 0; t < 10; t++) cs[t] = 4'(t + 1);
    build();
    run(3, 5, 0);
    build();
    run(-1, 0, 1);
    build();
    do_start();
    for (int t = 0; t < 5; t++) feed(t, 0);
    k = 0;
    while (!(bus.wr_en && bus.wr_tap == 4 && bus.wr_addr == 7) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("mid_load_addr", int'(bus.wr_addr), 7);
    chk("mid_load_tap", int'(bus.wr_tap), 4);
    #1 rst = 1;
    #1 chk_zero("async_rst");
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_ready", int'(bus.coef_ready), 0);
    build();
    run(-1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
